// File: rtl/frame_serializer.sv
// frame_serializer: frame FIFO feeding an MSB-first SBITS-wide serializer with programmable beat clock
module frame_serializer #(
  parameter int FRAME_W = 32,
  parameter int SBITS   = 4,
  parameter int DEPTH   = 4,
  parameter int DEF_DIV = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               FrameValid,
  input  logic [FRAME_W-1:0] FrameIn,
  output logic               FrameReady,
  input  logic               ConfigDiv,
  input  logic [31:0]        Din,
  output logic               ConfigErr,
  output logic               TxBusy,
  output logic               ClkTx,
  output logic               DoutValid,
  output logic [SBITS-1:0]   DataOut
);
  localparam int BEATS = FRAME_W / SBITS;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [FRAME_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [FRAME_W-1:0] shreg;
  logic [BW-1:0] beat;
  logic [31:0] cyc, div, d_eff;
  logic end_half, frame_done, pop, push, cfg_ok;
  // A pop frees a slot on the same edge, so a full FIFO still takes a frame then.
  always_comb begin
    d_eff = div == '0 ? 32'd1 : div;
    end_half = cyc == d_eff - 32'd1;
    frame_done = state == SHIFT && end_half && ClkTx && beat == BW'(BEATS - 1);
    pop = count != '0 && (state == IDLE || frame_done);
    push = FrameValid && !Reset && (count < CW'(DEPTH) || pop);
    cfg_ok = state == IDLE && count == '0 && !push;
    FrameReady = !Reset && count < CW'(DEPTH);
    TxBusy = state == SHIFT || count != '0;
  end
  // Frame FIFO storage, pointers and occupancy.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr_ptr] <= FrameIn;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // Serializer FSM: each beat is D cycles with ClkTx low then D cycles high.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      shreg <= '0;
      beat <= '0;
      cyc <= '0;
      div <= 32'(DEF_DIV);
      ClkTx <= 1'b0;
      DoutValid <= 1'b0;
      DataOut <= '0;
      ConfigErr <= 1'b0;
    end else begin
      ConfigErr <= ConfigDiv && !cfg_ok;
      if (ConfigDiv && cfg_ok) div <= Din;
      if (pop) begin
        state <= SHIFT;
        shreg <= mem[rd_ptr] << SBITS;
        DataOut <= mem[rd_ptr][FRAME_W-1 -: SBITS];
        DoutValid <= 1'b1;
        ClkTx <= 1'b0;
        cyc <= '0;
        beat <= '0;
      end else if (frame_done) begin
        state <= IDLE;
        DoutValid <= 1'b0;
        DataOut <= '0;
        ClkTx <= 1'b0;
        cyc <= '0;
        beat <= '0;
      end else if (state == SHIFT) begin
        if (!end_half) begin
          cyc <= cyc + 32'd1;
        end else if (!ClkTx) begin
          ClkTx <= 1'b1;
          cyc <= '0;
        end else begin
          ClkTx <= 1'b0;
          cyc <= '0;
          beat <= beat + BW'(1);
          DataOut <= shreg[FRAME_W-1 -: SBITS];
          shreg <= shreg << SBITS;
        end
      end
    end
  end
endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer: directed/random stimulus checked against a frame-queue beat model
module tb_frame_serializer;
  localparam int FRAME_W = 32;
  localparam int SBITS = 4;
  localparam int DEPTH = 4;
  localparam int DEF_DIV = 1;
  localparam int BEATS = FRAME_W / SBITS;
  logic Clk = 0, Reset = 1, FrameValid = 0, ConfigDiv = 0;
  logic [FRAME_W-1:0] FrameIn = '0;
  logic [31:0] Din = '0;
  logic FrameReady, ConfigErr, TxBusy, ClkTx, DoutValid;
  logic [SBITS-1:0] DataOut;
  int checks = 0, failures = 0;
  logic [FRAME_W-1:0] exp_q [$];
  logic [FRAME_W-1:0] fa, fb;
  frame_serializer #(.FRAME_W(FRAME_W), .SBITS(SBITS), .DEPTH(DEPTH), .DEF_DIV(DEF_DIV)) dut (
    .Clk(Clk), .Reset(Reset), .FrameValid(FrameValid), .FrameIn(FrameIn), .FrameReady(FrameReady),
    .ConfigDiv(ConfigDiv), .Din(Din), .ConfigErr(ConfigErr), .TxBusy(TxBusy), .ClkTx(ClkTx),
    .DoutValid(DoutValid), .DataOut(DataOut));
  always #5 Clk = ~Clk;
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [FRAME_W-1:0] f);
    FrameValid = 1;
    FrameIn = f;
    exp_q.push_back(f);
    step();
    FrameValid = 0;
  endtask
  function automatic logic [SBITS-1:0] nib(input logic [FRAME_W-1:0] f, input int i);
    return SBITS'(f >> (FRAME_W - SBITS * (i + 1)));
  endfunction
  // Expects nframes queued frames back-to-back, each beat 2*d cycles, then idle outputs.
  task automatic run_check(input int nframes, input int d);
    int k;
    logic [FRAME_W-1:0] fr;
    k = 0;
    while (!DoutValid && k < 100) begin
      step();
      k++;
    end
    chk("start_valid", DoutValid, 1);
    for (int f = 0; f < nframes; f++) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL queue_empty observed=0 expected=%0d", nframes - f);
        return;
      end
      fr = exp_q.pop_front();
      for (int i = 0; i < BEATS; i++)
        for (int c = 0; c < 2 * d; c++) begin
          chk("valid", DoutValid, 1);
          chk("data", DataOut, nib(fr, i));
          chk("clktx", ClkTx, c >= d);
          step();
        end
    end
    chk("idle_valid", DoutValid, 0);
    chk("idle_data", DataOut, 0);
    chk("idle_clktx", ClkTx, 0);
    chk("idle_busy", TxBusy, 0);
  endtask
  initial begin
    repeat (3) step();
    chk("rst_ready", FrameReady, 0);
    Reset = 0;
    step();
    chk("ready_after_rst", FrameReady, 1);
    chk("rst_cfgerr", ConfigErr, 0);
    chk("rst_busy", TxBusy, 0);
    chk("rst_clktx", ClkTx, 0);
    chk("rst_valid", DoutValid, 0);
    chk("rst_data", DataOut, 0);
    ConfigDiv = 1;
    Din = 3;
    step();
    ConfigDiv = 0;
    chk("cfg3_err", ConfigErr, 0);
    fork
      run_check(3, 3);
      begin
        push(32'h1234ABCD);
        push($urandom);
        push($urandom);
      end
    join
    ConfigDiv = 1;
    Din = 0;
    step();
    ConfigDiv = 0;
    chk("cfg0_err", ConfigErr, 0);
    fork
      run_check(1, 1);
      push($urandom);
    join
    ConfigDiv = 1;
    Din = 1;
    step();
    ConfigDiv = 0;
    fork
      run_check(6, 1);
      begin
        for (int n = 0; n < 5; n++) begin
          chk("ready_fill", FrameReady, 1);
          FrameValid = 1;
          FrameIn = $urandom;
          exp_q.push_back(FrameIn);
          step();
        end
        chk("ready_full", FrameReady, 0);
        chk("busy_full", TxBusy, 1);
        FrameIn = 32'hDEADBEEF;
        step();
        FrameValid = 0;
        chk("ready_drop", FrameReady, 0);
        repeat (11) step();
        FrameValid = 1;
        FrameIn = $urandom;
        exp_q.push_back(FrameIn);
        step();
        FrameValid = 0;
        chk("ready_full_pp", FrameReady, 0);
      end
    join
    ConfigDiv = 1;
    Din = 2;
    step();
    ConfigDiv = 0;
    fork
      run_check(1, 2);
      begin
        ConfigDiv = 1;
        Din = 5;
        FrameValid = 1;
        FrameIn = $urandom;
        exp_q.push_back(FrameIn);
        step();
        FrameValid = 0;
        ConfigDiv = 0;
        chk("cfg_push_err", ConfigErr, 1);
        step();
        chk("cfg_push_err_end", ConfigErr, 0);
        repeat (3) step();
        ConfigDiv = 1;
        Din = 7;
        step();
        ConfigDiv = 0;
        chk("cfg_shift_err", ConfigErr, 1);
        step();
        chk("cfg_shift_err_end", ConfigErr, 0);
      end
    join
    fa = $urandom;
    fb = $urandom;
    FrameValid = 1;
    FrameIn = fa;
    step();
    FrameIn = fb;
    step();
    FrameValid = 0;
    repeat (12) step();
    chk("pre_rst_valid", DoutValid, 1);
    chk("pre_rst_beat3", DataOut, nib(fa, 3));
    Reset = 1;
    step();
    chk("abort_valid", DoutValid, 0);
    chk("abort_data", DataOut, 0);
    chk("abort_busy", TxBusy, 0);
    chk("abort_clktx", ClkTx, 0);
    chk("abort_ready", FrameReady, 0);
    Reset = 0;
    step();
    chk("abort_ready_after", FrameReady, 1);
    fork
      run_check(1, DEF_DIV);
      push($urandom);
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
